// File: rtl/spatz_pkg.sv
// Shared types and default sizes for the Spatz issue buffer.
package spatz_pkg;

    localparam int IdWidth               = 4;
    localparam int VtypeWidth            = 8;
    localparam int VlWidth               = 16;
    localparam int DefaultDepth          = 4;
    localparam int DefaultMaxOutstanding = 8;

    typedef logic [IdWidth-1:0] spatz_id_t;

    // Decoded vector request handed from the controller to the VFU.
    typedef struct packed {
        spatz_id_t              id;
        logic [VtypeWidth-1:0]  vtype;
        logic [VlWidth-1:0]     vl;
        logic [VlWidth-1:0]     vstart;
    } spatz_req_t;

    // VFU completion; the id identifies which issued request retired.
    typedef struct packed {
        spatz_id_t id;
    } vfu_rsp_t;

endpackage

// File: rtl/spatz_issue_fifo.sv
// Generic synchronous FIFO with an occupancy counter; pointers wrap at Depth,
// so Depth does not need to be a power of two.
module spatz_issue_fifo #(
    parameter type T     = logic,
    parameter int  Depth = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push_i,
    input  T     data_i,
    input  logic pop_i,
    output T     data_o,
    output logic full_o,
    output logic empty_o
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

    T                mem [Depth];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] cnt_q;
    logic            do_push;
    logic            do_pop;

    assign full_o  = (cnt_q == FullCnt);
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem[rd_ptr_q];

    // Storage array: written on push only, no reset needed for payload.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr_q] <= data_i;
        end
    end

    // Pointer and occupancy bookkeeping; reset empties the queue.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (!do_push && do_pop) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/spatz_issue_buffer.sv
// Issue buffer between the Spatz controller and a VFU: buffers decoded
// requests, tracks issued ids in order, and bounds the number of requests
// that are accepted but not yet completed.
module spatz_issue_buffer
    import spatz_pkg::*;
#(
    parameter int Depth          = DefaultDepth,
    parameter int MaxOutstanding = DefaultMaxOutstanding
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                req_valid_i,
    output logic                                req_ready_o,
    input  spatz_req_t                          req_i,
    output logic                                vfu_req_valid_o,
    input  logic                                vfu_req_ready_i,
    output spatz_req_t                          vfu_req_o,
    input  logic                                vfu_rsp_valid_i,
    input  vfu_rsp_t                            vfu_rsp_i,
    output logic [$clog2(MaxOutstanding+1)-1:0] outstanding_o,
    output logic                                idle_o,
    output logic                                err_o
);

    localparam int OutW = $clog2(MaxOutstanding + 1);
    localparam logic [OutW-1:0] MaxOut = OutW'(MaxOutstanding);

    logic            req_full;
    logic            req_empty;
    logic            infl_full;
    logic            infl_empty;
    spatz_id_t       infl_head;
    logic            push;
    logic            pop;
    logic            rsp_ok;
    logic            rsp_bad;
    logic [OutW-1:0] outstanding_q;
    logic            err_q;

    // Ready depends only on registered state. The in-flight-full term is
    // implied by the credit limit and only keeps that queue from overflowing.
    assign req_ready_o     = !req_full && !infl_full && (outstanding_q < MaxOut);
    assign push            = req_valid_i && req_ready_o;
    assign vfu_req_valid_o = !req_empty;
    assign pop             = vfu_req_valid_o && vfu_req_ready_i;

    // A completion retires the oldest issued id; a mismatch or an empty
    // in-flight queue is a protocol error.
    assign rsp_ok  = vfu_rsp_valid_i && !infl_empty;
    assign rsp_bad = vfu_rsp_valid_i && (infl_empty || (vfu_rsp_i.id != infl_head));

    assign outstanding_o = outstanding_q;
    assign idle_o        = (outstanding_q == '0);
    assign err_o         = err_q;

    spatz_issue_fifo #(
        .T     (spatz_req_t),
        .Depth (Depth)
    ) i_req_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .data_i  (req_i),
        .pop_i   (pop),
        .data_o  (vfu_req_o),
        .full_o  (req_full),
        .empty_o (req_empty)
    );

    spatz_issue_fifo #(
        .T     (spatz_id_t),
        .Depth (MaxOutstanding)
    ) i_infl_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (pop),
        .data_i  (vfu_req_o.id),
        .pop_i   (rsp_ok),
        .data_o  (infl_head),
        .full_o  (infl_full),
        .empty_o (infl_empty)
    );

    // Outstanding credit counter and sticky error flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            outstanding_q <= '0;
            err_q         <= 1'b0;
        end else begin
            outstanding_q <= outstanding_q + OutW'(push) - OutW'(rsp_ok);
            if (rsp_bad) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spatz_issue_buffer.sv
// Scoreboard bench for spatz_issue_buffer: accepted requests are queued as
// expected VFU issues, issued ids are queued as expected completions.
module tb_spatz_issue_buffer;
    import spatz_pkg::*;

    localparam int DEPTH = 4;
    localparam int MAXO  = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    spatz_req_t req = '0;
    logic       vfu_valid;
    logic       vfu_ready = 1'b0;
    spatz_req_t vfu_req;
    logic       rsp_valid = 1'b0;
    vfu_rsp_t   rsp = '0;
    logic [3:0] outstanding;
    logic       idle;
    logic       err;

    spatz_issue_buffer #(
        .Depth          (DEPTH),
        .MaxOutstanding (MAXO)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_i           (req),
        .vfu_req_valid_o (vfu_valid),
        .vfu_req_ready_i (vfu_ready),
        .vfu_req_o       (vfu_req),
        .vfu_rsp_valid_i (rsp_valid),
        .vfu_rsp_i       (rsp),
        .outstanding_o   (outstanding),
        .idle_o          (idle),
        .err_o           (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    spatz_req_t exp_q[$];
    spatz_id_t  infl_q[$];
    int         m_out = 0;
    bit         m_err = 1'b0;
    bit         acc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic spatz_req_t make_req(input int id);
        spatz_req_t r;
        r.id     = spatz_id_t'(id);
        r.vtype  = 8'(id * 3 + 1);
        r.vl     = 16'(id + 100);
        r.vstart = 16'(id);
        return r;
    endfunction

    // Inputs are set at the falling edge; outputs are sampled 1 time unit
    // later, compared against the model, then the model takes the edge.
    task automatic tick();
        bit m_ready;
        bit do_push;
        bit do_pop;
        bit do_cpl;
        spatz_req_t e;
        #1;
        m_ready = (exp_q.size() < DEPTH) && (m_out < MAXO);
        check("req_ready", req_ready, m_ready);
        check("vfu_valid", vfu_valid, exp_q.size() != 0);
        check("outstanding", outstanding, m_out);
        check("idle", idle, m_out == 0);
        check("err", err, m_err);
        do_push = req_valid && m_ready;
        do_pop  = vfu_ready && (exp_q.size() != 0);
        do_cpl  = 1'b0;
        if (rsp_valid) begin
            if (infl_q.size() == 0) begin
                m_err = 1'b1;
            end else begin
                if (rsp.id != infl_q[0]) m_err = 1'b1;
                void'(infl_q.pop_front());
                do_cpl = 1'b1;
            end
        end
        if (do_pop) begin
            e = exp_q.pop_front();
            check("vfu_req", vfu_req, e);
            infl_q.push_back(e.id);
        end
        if (do_push) exp_q.push_back(req);
        m_out = m_out + int'(do_push) - int'(do_cpl);
        acc = do_push;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        infl_q.delete();
        m_out = 0;
        m_err = 1'b0;
    endtask

    task automatic idle_inputs();
        req_valid = 1'b0;
        vfu_ready = 1'b0;
        rsp_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        int tries;
        @(negedge clk);
        do_reset();
        #1;
        check("rst_ready", req_ready, 1'b1);
        check("rst_valid", vfu_valid, 1'b0);
        check("rst_out", outstanding, 0);
        check("rst_idle", idle, 1'b1);
        check("rst_err", err, 1'b0);

        // Single request, then its completion.
        req = make_req(3); req_valid = 1'b1; vfu_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        check("single_valid", vfu_valid, 1'b1);
        tick();
        check("single_out_after_pop", outstanding, 1);
        vfu_ready = 1'b0;
        rsp.id = 4'd3; rsp_valid = 1'b1;
        tick();
        rsp_valid = 1'b0;
        check("single_out_done", outstanding, 0);
        check("single_idle", idle, 1'b1);

        // Fill the buffer with the VFU stalled, then drain in order.
        for (int i = 0; i < 4; i++) begin
            req = make_req(i); req_valid = 1'b1;
            tick();
        end
        req_valid = 1'b0;
        check("fill_ready", req_ready, 1'b0);
        check("fill_stable", vfu_req, make_req(0));
        vfu_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        vfu_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rsp.id = spatz_id_t'(i); rsp_valid = 1'b1;
            tick();
        end
        rsp_valid = 1'b0;
        tick();

        // Credit limit with an empty buffer.
        vfu_ready = 1'b1; req_valid = 1'b1;
        k = 0; tries = 0;
        while (k < 8 && tries < 40) begin
            req = make_req(k);
            tick();
            if (acc) k++;
            tries++;
        end
        check("credit_accepts", k, 8);
        req = make_req(9);
        tick();
        tick();
        check("credit_ready", req_ready, 1'b0);
        check("credit_empty", vfu_valid, 1'b0);
        req_valid = 1'b0;
        rsp.id = 4'd0; rsp_valid = 1'b1;
        tick();
        rsp_valid = 1'b0;
        check("credit_ready_back", req_ready, 1'b1);
        for (int i = 1; i < 8; i++) begin
            rsp.id = spatz_id_t'(i); rsp_valid = 1'b1;
            tick();
        end
        idle_inputs();
        tick();

        // Out-of-order completion raises a sticky error.
        vfu_ready = 1'b1; req_valid = 1'b1;
        req = make_req(5); tick();
        req = make_req(6); tick();
        req_valid = 1'b0;
        tick();
        rsp.id = 4'd6; rsp_valid = 1'b1;
        tick();
        rsp_valid = 1'b0;
        check("order_err", err, 1'b1);
        check("order_out", outstanding, 1);
        tick(); tick();
        check("order_err_sticky", err, 1'b1);
        idle_inputs();
        do_reset();

        // Completion with nothing in flight.
        rsp.id = 4'd2; rsp_valid = 1'b1;
        tick();
        rsp_valid = 1'b0;
        check("spur_err", err, 1'b1);
        check("spur_out", outstanding, 0);
        do_reset();

        // Reset with requests both buffered and in flight.
        vfu_ready = 1'b1; req_valid = 1'b1;
        req = make_req(1); tick();
        req = make_req(2); tick();
        vfu_ready = 1'b0;
        for (int i = 3; i < 6; i++) begin
            req = make_req(i); tick();
        end
        req_valid = 1'b0;
        check("mid_out", outstanding, 5);
        rsp.id = 4'd1; rsp_valid = 1'b1;
        do_reset();
        rsp_valid = 1'b0;
        #1;
        check("mid_valid", vfu_valid, 1'b0);
        check("mid_out_rst", outstanding, 0);
        check("mid_err", err, 1'b0);
        vfu_ready = 1'b1;
        tick(); tick();

        // Random traffic with in-order completions.
        for (int c = 0; c < 400; c++) begin
            req = make_req(int'($urandom_range(0, 15)));
            req_valid = ($urandom_range(0, 3) != 0);
            vfu_ready = ($urandom_range(0, 2) != 0);
            rsp_valid = 1'b0;
            if (infl_q.size() != 0 && $urandom_range(0, 2) == 0) begin
                rsp.id = infl_q[0];
                rsp_valid = 1'b1;
            end
            tick();
        end
        idle_inputs();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
